// File: rtl/shift_pipe_pkg.sv
// Shared constants and elaboration helpers for the pipelined barrel shifter.
// Op bit positions, a clog2 function, and the mapping of shift levels onto stages.
package shift_pipe_pkg;

    localparam int OP_RIGHT = 0;
    localparam int OP_ARITH = 1;
    localparam int OP_ROT   = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    function automatic int level_stage(input int k, input int stages, input int saw);
        return (k * stages) / saw;
    endfunction

    // With stages <= saw every stage owns at least one level, so these never fall through.
    function automatic int stage_first(input int i, input int stages, input int saw);
        int f;
        f = saw;
        for (int k = saw - 1; k >= 0; k--) begin
            if (level_stage(k, stages, saw) == i) f = k;
        end
        return f;
    endfunction

    function automatic int stage_last(input int i, input int stages, input int saw);
        int l;
        l = -1;
        for (int k = 0; k < saw; k++) begin
            if (level_stage(k, stages, saw) == i) l = k;
        end
        return l;
    endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One pipeline stage: shift levels FIRST..LAST followed by a valid/ready register.
// Rotate levels exist only when SHIFT_PIPE_ROTATE_EN is defined.
module shift_pipe_stage
    import shift_pipe_pkg::*;
#(
    parameter int W     = 32,
    parameter int SAW   = 5,
    parameter int FIRST = 0,
    parameter int LAST  = 4
) (
    input  logic           clk,
    input  logic           clrn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_d,
    input  logic [SAW-1:0] in_sa,
    input  logic [2:0]     in_op,
    input  logic           in_sign,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_d,
    output logic [SAW-1:0] out_sa,
    output logic [2:0]     out_op,
    output logic           out_sign,
    output logic           out_zero
);

    // Op arrives pre-decoded: arith is only set for a non-rotating right shift.
    function automatic logic [W-1:0] shift_level(input logic [W-1:0] d, input int s,
                                                 input logic [2:0] op, input logic sign);
        logic [W-1:0] fill;
        fill = {W{sign}} << (W - s);
`ifdef SHIFT_PIPE_ROTATE_EN
        if (op[OP_ROT]) begin
            if (op[OP_RIGHT]) return (d >> s) | (d << (W - s));
            return (d << s) | (d >> (W - s));
        end
`endif
        if (!op[OP_RIGHT]) return d << s;
        if (op[OP_ARITH]) return (d >> s) | fill;
        return d >> s;
    endfunction

    logic [W-1:0] lvl [FIRST:LAST+1];

    assign lvl[FIRST] = in_d;

    for (genvar k = FIRST; k <= LAST; k++) begin : g_lvl
        assign lvl[k+1] = in_sa[k] ? shift_level(lvl[k], 1 << k, in_op, in_sign) : lvl[k];
    end

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            out_valid <= 1'b0;
            out_d     <= '0;
            out_sa    <= '0;
            out_op    <= '0;
            out_sign  <= 1'b0;
            out_zero  <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_d    <= lvl[LAST+1];
                out_sa   <= in_sa;
                out_op   <= in_op;
                out_sign <= in_sign;
                out_zero <= (lvl[LAST+1] == '0);
            end
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: log2(W) shift levels spread over STAGES valid/ready stages.
// Define SHIFT_PIPE_ROTATE_EN to build rotates; otherwise op[2] is ignored.
module shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter  int W      = 32,
    parameter  int STAGES = 2,
    localparam int SAW    = clog2(W)
) (
    input  logic           clk,
    input  logic           clrn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_d,
    input  logic [SAW-1:0] in_sa,
    input  logic [2:0]     in_op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_sh,
    output logic           out_zero
);

    logic [STAGES:0]   v;
    logic [STAGES:0]   rdy;
    logic [STAGES:0]   sg;
    logic [STAGES-1:0] zv;
    logic [W-1:0]      d  [0:STAGES];
    logic [SAW-1:0]    sa [0:STAGES];
    logic [2:0]        op [0:STAGES];

    assign v[0]        = in_valid;
    assign in_ready    = rdy[0];
    assign rdy[STAGES] = out_ready;
    assign d[0]        = in_d;
    assign sa[0]       = in_sa;
    assign sg[0]       = in_d[W-1];

`ifdef SHIFT_PIPE_ROTATE_EN
    assign op[0] = {in_op[OP_ROT], in_op[OP_ARITH] & in_op[OP_RIGHT] & ~in_op[OP_ROT],
                    in_op[OP_RIGHT]};
`else
    assign op[0] = {1'b0, in_op[OP_ARITH] & in_op[OP_RIGHT], in_op[OP_RIGHT]};
`endif

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        shift_pipe_stage #(
            .W    (W),
            .SAW  (SAW),
            .FIRST(stage_first(i, STAGES, SAW)),
            .LAST (stage_last(i, STAGES, SAW))
        ) u_stage (
            .clk      (clk),
            .clrn     (clrn),
            .in_valid (v[i]),
            .in_ready (rdy[i]),
            .in_d     (d[i]),
            .in_sa    (sa[i]),
            .in_op    (op[i]),
            .in_sign  (sg[i]),
            .out_valid(v[i+1]),
            .out_ready(rdy[i+1]),
            .out_d    (d[i+1]),
            .out_sa   (sa[i+1]),
            .out_op   (op[i+1]),
            .out_sign (sg[i+1]),
            .out_zero (zv[i])
        );
    end

    assign out_valid = v[STAGES];
    assign out_sh    = d[STAGES];
    assign out_zero  = zv[STAGES-1];

    // Side-band state leaving the final stage has no consumer.
    logic unused_tail;
    assign unused_tail = ^{sa[STAGES], op[STAGES], sg[STAGES], zv, in_op};

endmodule

// File: tb/tb_shift_pipe.sv
// Bench for shift_pipe: three configurations, each checked every cycle against a queue model.
// Rotate expectations follow SHIFT_PIPE_ROTATE_EN as seen by this compile.
`timescale 1ns/1ps
module tb_shift_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

`ifdef SHIFT_PIPE_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    // Reference result straight from the op rules on a w-bit value.
    function automatic logic [63:0] ref_shift(input logic [63:0] din, input int sa,
                                              input logic [2:0] op, input int w);
        logic [63:0] mask, d, r;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        d = din & mask;
        if (op[2] && ROT_EN) begin
            if (op[0]) r = (d >> sa) | (d << (w - sa));
            else       r = (d << sa) | (d >> (w - sa));
        end else if (op[0] && op[1]) begin
            r = d >> sa;
            if (d[w-1]) r = r | (mask & ~(mask >> sa));
        end else if (op[0]) begin
            r = d >> sa;
        end else begin
            r = d << sa;
        end
        return r & mask;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int W      = (g == 0) ? 32 : (g == 1) ? 8 : 64;
        localparam int STAGES = (g == 0) ? 2 : (g == 1) ? 1 : 6;
        localparam int SAW    = $clog2(W);

        logic           clrn, in_valid, in_ready, out_valid, out_ready, out_zero;
        logic [W-1:0]   in_d, out_sh;
        logic [SAW-1:0] in_sa;
        logic [2:0]     in_op;
        logic [W-1:0]   exp_q [$];
        int             pops = 0;
        bit             fin = 1'b0;
        logic           xfer_in = 1'b0;
        logic           held = 1'b0;
        logic [W-1:0]   held_sh;
        logic           held_z;

        shift_pipe #(.W(W), .STAGES(STAGES)) dut (
            .clk      (clk),
            .clrn     (clrn),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .in_d     (in_d),
            .in_sa    (in_sa),
            .in_op    (in_op),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .out_sh   (out_sh),
            .out_zero (out_zero)
        );

        // Compare process: what is visible now is what the next rising edge transfers.
        always @(negedge clk) begin
            logic [W-1:0] e;
            if (held) begin
                vectors++;
                if (!out_valid || out_sh !== held_sh || out_zero !== held_z) begin
                    miscompares++;
                    $display("FAIL stall_hold W=%0d: valid=%b sh=%h zero=%b, required valid=1 sh=%h zero=%b",
                             W, out_valid, out_sh, out_zero, held_sh, held_z);
                end
            end
            held    = clrn && out_valid && !out_ready;
            held_sh = out_sh;
            held_z  = out_zero;
            xfer_in = clrn && in_valid && in_ready;
            if (!clrn) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    vectors++;
                    pops++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL spurious_result W=%0d: got %h, required no result", W, out_sh);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_sh !== e || out_zero !== (e == '0)) begin
                            miscompares++;
                            $display("FAIL result W=%0d: got %h zero=%b, required %h zero=%b",
                                     W, out_sh, out_zero, e, (e == '0));
                        end
                    end
                end
                if (xfer_in) exp_q.push_back(W'(ref_shift(64'(in_d), int'(in_sa), in_op, W)));
            end
        end

        task automatic do_reset();
            clrn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            in_d = '0; in_sa = '0; in_op = '0;
            tick();
            tick();
            clrn = 1'b1;
        endtask

        task automatic random_run(input int n_ops);
            int sent, budget;
            sent = 0;
            budget = 0;
            while ((sent < n_ops || exp_q.size() != 0 || out_valid) && budget < 20 * n_ops + 100) begin
                tick();
                budget++;
                if (xfer_in) sent++;
                if (!in_valid || xfer_in) begin
                    if (sent < n_ops && $urandom_range(0, 3) != 0) begin
                        in_valid = 1'b1;
                        in_d     = W'({$urandom, $urandom});
                        in_sa    = SAW'($urandom);
                        in_op    = 3'($urandom);
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                out_ready = ($urandom_range(0, 9) < 7);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            chk($sformatf("random_drain W=%0d", W), {63'd0, (sent == n_ops && exp_q.size() == 0)}, 64'd1);
        endtask

        if (g == 0) begin : g_dir
            task automatic one_op(input string name, input logic [31:0] d, input int sa,
                                  input logic [2:0] op, input logic [31:0] exp);
                int k;
                in_valid = 1'b1; in_d = d; in_sa = SAW'(sa); in_op = op; out_ready = 1'b1;
                @(negedge clk);
                chk({name, " in_ready"}, in_ready, 64'd1);
                tick();
                in_valid = 1'b0;
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!out_valid && k < 10);
                chk({name, " latency"}, k, STAGES);
                chk({name, " out_sh"}, out_sh, exp);
                chk({name, " out_zero"}, out_zero, (exp == 32'd0));
                tick();
            endtask

            task automatic backpressure();
                logic [31:0] bd [4];
                int sent, p0, cycles;
                bd = '{32'h12345678, 32'h80000001, 32'hdeadbeef, 32'h0000f00f};
                p0 = pops;
                sent = 0;
                out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    in_valid = 1'b1; in_d = bd[sent]; in_sa = SAW'(sent + 3); in_op = 3'(sent);
                    @(negedge clk);
                    if (in_ready) sent++;
                    tick();
                end
                chk("bp accepts while stalled", sent, STAGES);
                chk("bp in_ready when full", in_ready, 64'd0);
                out_ready = 1'b1;
                cycles = 0;
                while ((sent < 4 || pops - p0 < 4) && cycles < 50) begin
                    in_valid = (sent < 4);
                    if (sent < 4) begin
                        in_d = bd[sent]; in_sa = SAW'(sent + 3); in_op = 3'(sent);
                    end
                    @(negedge clk);
                    if (in_valid && in_ready) sent++;
                    tick();
                    cycles++;
                end
                in_valid = 1'b0;
                chk("bp results delivered", pops - p0, 64'd4);
            endtask

            task automatic reset_midflight();
                logic seen;
                out_ready = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    in_valid = 1'b1; in_d = 32'hff0000ff; in_sa = SAW'(4 + i); in_op = 3'b001;
                    tick();
                end
                in_valid = 1'b0;
                clrn = 1'b0;
                tick();
                clrn = 1'b1;
                @(negedge clk);
                chk("rst out_valid", out_valid, 64'd0);
                chk("rst out_sh", out_sh, 64'd0);
                chk("rst out_zero", out_zero, 64'd0);
                out_ready = 1'b1;
                seen = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    seen = seen | out_valid;
                end
                chk("rst no late result", seen, 64'd0);
                tick();
            endtask

            initial begin
                do_reset();
                @(negedge clk);
                chk("reset out_valid", out_valid, 64'd0);
                chk("reset out_sh", out_sh, 64'd0);
                chk("reset out_zero", out_zero, 64'd0);
                chk("reset in_ready", in_ready, 64'd1);
                tick();
                one_op("sll8", 32'hff0000ff, 8, 3'b000, 32'h0000ff00);
                one_op("srl8", 32'hff0000ff, 8, 3'b001, 32'h00ff0000);
                one_op("sra8", 32'hff0000ff, 8, 3'b011, 32'hffff0000);
                one_op("rol8", 32'hff0000ff, 8, 3'b100, ROT_EN ? 32'h0000ffff : 32'h0000ff00);
                one_op("ror8", 32'hff0000ff, 8, 3'b101, ROT_EN ? 32'hffff0000 : 32'h00ff0000);
                for (int op = 0; op < 8; op++) begin
                    one_op($sformatf("sa0 op%0d", op), 32'hff0000ff, 0, 3'(op), 32'hff0000ff);
                end
                one_op("sra31", 32'h80000000, 31, 3'b011, 32'hffffffff);
                one_op("sll31 one", 32'h00000001, 31, 3'b000, 32'h80000000);
                one_op("sll31 zero", 32'h00000002, 31, 3'b000, 32'h00000000);
                backpressure();
                reset_midflight();
                random_run(400);
                fin = 1'b1;
            end
        end else begin : g_rnd
            initial begin
                do_reset();
                random_run(400);
                fin = 1'b1;
            end
        end
    end

    initial begin
        fork
            wait (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin);
            repeat (60000) @(posedge clk);
        join_any
        disable fork;
        vectors++;
        if (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin)) begin
            miscompares++;
            $display("FAIL run_timeout: fin=%b%b%b, required 111",
                     g_cfg[0].fin, g_cfg[1].fin, g_cfg[2].fin);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
